// File: rtl/vga_text_pkg.sv
// Shared constants and helpers for the on-screen text formatting blocks.
package vga_text_pkg;

  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_HASH  = 8'h23;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FORMAT = 2'd2
  } state_t;

  // BCD nibbles needed to hold any VAL_W-bit magnitude: ceil(VAL_W*log10(2)) + 1.
  function automatic int n_bcd(input int val_w);
    return (val_w * 30103 + 99999) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction for one BCD digit: values 5..9 get +3 before the shift.
module bcd_add3_nibble (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/vga_num_to_ascii.sv
// Multi-cycle binary-to-decimal ASCII formatter feeding the glyph renderers.
// Results are registered in one edge so displayed text never tears.
module vga_num_to_ascii
  import vga_text_pkg::*;
#(
  parameter int VAL_W    = 16,
  parameter int N_DIGITS = 5,
  parameter bit SIGNED   = 1'b0,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk_pix,
  input  logic                  rst_pix_n,
  input  logic                  start,
  input  logic [VAL_W-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [8*N_DIGITS-1:0] digits_ascii,
  output logic [7:0]            sign_char,
  output logic                  overflow
);

  localparam int N_BCD = n_bcd(VAL_W);
  localparam int N_ALL = (N_BCD > N_DIGITS) ? N_BCD : N_DIGITS;
  localparam int CNT_W = $clog2(VAL_W + 1);

  // All spaces, with byte0 flipped from ' ' to '0' (they differ only in bit 4).
  localparam logic [8*N_DIGITS-1:0] DIG_RST =
    {N_DIGITS{ASC_SPACE}} ^ (8*N_DIGITS)'(ASC_SPACE ^ ASC_ZERO);

  state_t                 state;
  logic [4*N_BCD-1:0]     bcd;
  logic [4*N_BCD-1:0]     bcd_adj;
  logic [VAL_W-1:0]       mag;
  logic [CNT_W-1:0]       cnt;
  logic                   neg;

  logic [4*N_ALL-1:0]     bcd_ext;
  logic [8*N_DIGITS-1:0]  dig_c;
  logic [7:0]             sign_c;
  logic                   ovf_c;
  logic                   lead;
  logic [3:0]             nib;

  for (genvar g = 0; g < N_BCD; g++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .din  (bcd[4*g +: 4]),
      .dout (bcd_adj[4*g +: 4])
    );
  end

  // Final BCD -> ASCII, evaluated from the settled accumulator in FORMAT.
  always_comb begin
    bcd_ext = '0;
    bcd_ext[4*N_BCD-1:0] = bcd;
    ovf_c = 1'b0;
    for (int i = N_DIGITS; i < N_ALL; i++)
      if (bcd_ext[4*i +: 4] != 4'd0) ovf_c = 1'b1;
    dig_c = '0;
    lead  = LZ_BLANK;
    nib   = 4'd0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      nib = bcd_ext[4*i +: 4];
      if (ovf_c)
        dig_c[8*i +: 8] = ASC_HASH;
      else if (lead && nib == 4'd0 && i != 0)
        dig_c[8*i +: 8] = ASC_SPACE;
      else begin
        dig_c[8*i +: 8] = ASC_ZERO + {4'h0, nib};
        lead = 1'b0;
      end
    end
    // A set sign flag implies a nonzero magnitude (its MSB was 1).
    sign_c = neg ? ASC_MINUS : ASC_SPACE;
  end

  always_ff @(posedge clk_pix or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
      sign_char    <= ASC_SPACE;
      digits_ascii <= DIG_RST;
      bcd          <= '0;
      mag          <= '0;
      cnt          <= '0;
      neg          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          neg   <= SIGNED && value[VAL_W-1];
          mag   <= (SIGNED && value[VAL_W-1]) ? -value : value;
          bcd   <= '0;
          cnt   <= CNT_W'(VAL_W);
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, mag} <= {bcd_adj, mag} << 1;
          cnt        <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) state <= FORMAT;
        end
        FORMAT: begin
          digits_ascii <= dig_c;
          sign_char    <= sign_c;
          overflow     <= ovf_c;
          done         <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_num_to_ascii.sv
// Four parameterisations share one stimulus stream; each is checked against
// an arithmetic (divide/modulo) model of the decimal string.
module tb_vga_num_to_ascii;

  logic        clk_pix = 1'b0;
  logic        rst_pix_n;
  logic        start;
  logic [15:0] value;

  logic d_busy, d_done, d_ovf; logic [39:0] d_dig; logic [7:0] d_sign;
  logic s_busy, s_done, s_ovf; logic [39:0] s_dig; logic [7:0] s_sign;
  logic n_busy, n_done, n_ovf; logic [23:0] n_dig; logic [7:0] n_sign;
  logic l_busy, l_done, l_ovf; logic [39:0] l_dig; logic [7:0] l_sign;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] prev_d = 40'h2020202030;

  always #5 clk_pix = ~clk_pix;

  vga_num_to_ascii #(.VAL_W(16), .N_DIGITS(5), .SIGNED(1'b0), .LZ_BLANK(1'b1)) u_def (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start), .value(value),
    .busy(d_busy), .done(d_done), .digits_ascii(d_dig), .sign_char(d_sign), .overflow(d_ovf));
  vga_num_to_ascii #(.VAL_W(16), .N_DIGITS(5), .SIGNED(1'b1), .LZ_BLANK(1'b1)) u_sgn (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start), .value(value),
    .busy(s_busy), .done(s_done), .digits_ascii(s_dig), .sign_char(s_sign), .overflow(s_ovf));
  vga_num_to_ascii #(.VAL_W(16), .N_DIGITS(3), .SIGNED(1'b0), .LZ_BLANK(1'b1)) u_n3 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start), .value(value),
    .busy(n_busy), .done(n_done), .digits_ascii(n_dig), .sign_char(n_sign), .overflow(n_ovf));
  vga_num_to_ascii #(.VAL_W(16), .N_DIGITS(5), .SIGNED(1'b0), .LZ_BLANK(1'b0)) u_lz0 (
    .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .start(start), .value(value),
    .busy(l_busy), .done(l_done), .digits_ascii(l_dig), .sign_char(l_sign), .overflow(l_ovf));

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [15:0] v, input bit sgn, input int nd, input bit lz,
                       output logic [39:0] dig, output logic [7:0] sc, output logic ovf);
    bit neg;
    int mag, pw;
    neg = sgn && v[15];
    mag = neg ? 65536 - int'(v) : int'(v);
    pw = 1;
    for (int i = 0; i < nd; i++) pw = pw * 10;
    ovf = (mag >= pw);
    dig = '0;
    pw = 1;
    for (int i = 0; i < nd; i++) begin
      if (ovf)                          dig[8*i +: 8] = 8'h23;
      else if (lz && i > 0 && mag < pw) dig[8*i +: 8] = 8'h20;
      else                              dig[8*i +: 8] = 8'h30 + 8'((mag / pw) % 10);
      pw = pw * 10;
    end
    sc = (neg && mag != 0) ? 8'h2D : 8'h20;
  endtask

  task automatic check_results(input logic [15:0] v);
    logic [39:0] e; logic [7:0] es; logic eo;
    model(v, 1'b0, 5, 1'b1, e, es, eo);
    chk("def digits", d_dig, e); chk("def sign", 40'(d_sign), 40'(es)); chk("def ovf", 40'(d_ovf), 40'(eo));
    prev_d = e;
    model(v, 1'b1, 5, 1'b1, e, es, eo);
    chk("sgn digits", s_dig, e); chk("sgn sign", 40'(s_sign), 40'(es)); chk("sgn ovf", 40'(s_ovf), 40'(eo));
    model(v, 1'b0, 3, 1'b1, e, es, eo);
    chk("n3 digits", 40'(n_dig), {16'h0, e[23:0]}); chk("n3 sign", 40'(n_sign), 40'(es)); chk("n3 ovf", 40'(n_ovf), 40'(eo));
    model(v, 1'b0, 5, 1'b0, e, es, eo);
    chk("lz0 digits", l_dig, e); chk("lz0 sign", 40'(l_sign), 40'(es)); chk("lz0 ovf", 40'(l_ovf), 40'(eo));
  endtask

  task automatic check_reset_state();
    chk("rst busy", 40'({d_busy, s_busy, n_busy, l_busy}), 40'h0);
    chk("rst done", 40'({d_done, s_done, n_done, l_done}), 40'h0);
    chk("rst ovf", 40'({d_ovf, s_ovf, n_ovf, l_ovf}), 40'h0);
    chk("rst sign", {8'h0, d_sign, s_sign, n_sign, l_sign}, 40'h0020202020);
    chk("rst def digits", d_dig, 40'h2020202030);
    chk("rst sgn digits", s_dig, 40'h2020202030);
    chk("rst n3 digits", 40'(n_dig), 40'h202030);
    chk("rst lz0 digits", l_dig, 40'h2020202030);
  endtask

  // Counts done pulses over a window in which none are expected.
  task automatic expect_quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk_pix);
      if (d_done || s_done || n_done || l_done) pulses++;
    end
    chk(tag, 40'(pulses), 40'd0);
  endtask

  // One conversion; optionally re-pulses start (with v2) after edge k+re_at.
  task automatic convert(input logic [15:0] v, input int re_at, input logic [15:0] v2);
    @(negedge clk_pix);
    value = v; start = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    chk("busy after start", 40'({d_busy, d_done}), 40'h2);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk_pix);
      start = (i == re_at) ? 1'b1 : 1'b0;
      if (i == re_at) value = v2;
      if (i < 17) chk("busy window", 40'({d_busy, d_done}), 40'h2);
      else        chk("done edge", 40'({d_busy, d_done, s_done, n_done, l_done}), 40'h0F);
      if (i == 8) chk("hold prev", d_dig, prev_d);
    end
    check_results(v);
    @(negedge clk_pix);
    start = 1'b0;
    chk("done one cycle", 40'({d_busy, d_done}), 40'h0);
  endtask

  initial begin
    rst_pix_n = 1'b0; start = 1'b0; value = '0;
    #12;
    check_reset_state();
    @(negedge clk_pix);
    rst_pix_n = 1'b1;

    convert(16'd12345, 0, 16'd0);
    convert(16'd7,     0, 16'd0);
    convert(16'd0,     0, 16'd0);
    convert(16'hFFF6,  0, 16'd0);
    convert(16'h8000,  0, 16'd0);
    convert(16'd1000,  0, 16'd0);
    convert(16'd999,   0, 16'd0);
    convert(16'd65535, 0, 16'd0);

    // start during SHIFT and on the FORMAT edge: both dropped
    convert(16'd4321, 5, 16'd777);
    expect_quiet("no second done (busy start)", 22);
    convert(16'd250, 16, 16'd31);
    expect_quiet("no second done (format start)", 22);

    // reset mid-conversion after a "00042" result
    convert(16'd42, 0, 16'd0);
    @(negedge clk_pix);
    value = 16'd1234; start = 1'b1;
    @(negedge clk_pix);
    start = 1'b0;
    repeat (7) @(negedge clk_pix);
    #2 rst_pix_n = 1'b0;
    #1 check_reset_state();
    @(negedge clk_pix);
    rst_pix_n = 1'b1;
    prev_d = 40'h2020202030;
    expect_quiet("no done after reset", 25);
    convert(16'd31337, 0, 16'd0);

    for (int r = 0; r < 24; r++) convert(16'($urandom_range(0, 65535)), 0, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1, "timeout");
  end

endmodule
